// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with match counting,
// threshold interrupt and optional idle timeout (`SEQDET_TIMEOUT_EN).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cfg_valid/ready     config handshake; cfg_pattern/len/overlap/thresh
//   start, stop         arm / abort a detection run
//   in, in_valid        qualified serial bit stream
//   match, match_cnt    match pulse and per-run match count
//   irq, irq_clr        threshold interrupt (level) and its clear
//   busy                state is not IDLE
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               start,
    input  logic               stop,
    input  logic               in,
    input  logic               in_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               irq,
    input  logic               irq_clr,
    output logic               busy
);

    localparam int FW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_hist;
    logic [FW-1:0]      r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [3:0]         r_len;
    logic               r_ovl;
    logic [CNT_W-1:0]   r_thr;
    logic               r_match;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_irq;

`ifdef SEQDET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      r_idle;
`endif

    logic [MAX_LEN-1:0] w_hist_nx;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;
    logic               w_len_ok;
    logic [FW-1:0]      w_fill_inc;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_hist_nx = {r_hist[MAX_LEN-2:0], in};

    // Only the low len bits of history/pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (4'(i) < r_len);
        end
    end

    // Enough bits collected (counting the one arriving now) and they agree.
    assign w_hit = (int'(r_fill) + 1 >= int'(r_len))
                && (((w_hist_nx ^ r_pat) & w_mask) == '0);

    assign w_len_ok = (r_len != 4'd0) && (int'(r_len) <= MAX_LEN);

    assign w_fill_inc = (r_fill == FW'(MAX_LEN)) ? r_fill
                                                 : r_fill + FW'(1);

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= '0;
            r_len   <= '0;
            r_ovl   <= 1'b0;
            r_thr   <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
`ifdef SEQDET_TIMEOUT_EN
            r_idle  <= '0;
`endif
        end else begin
            r_match <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_pat <= cfg_pattern;
                        r_len <= cfg_len;
                        r_ovl <= cfg_overlap;
                        r_thr <= cfg_thresh;
                    end
                    // start is judged against the config already latched.
                    if (start && w_len_ok) begin
                        r_state <= S_RUN;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_cnt   <= '0;
`ifdef SEQDET_TIMEOUT_EN
                        r_idle  <= '0;
`endif
                    end
                end
                S_RUN: begin
                    // stop wins: a bit arriving with it is dropped.
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        r_hist <= w_hist_nx;
`ifdef SEQDET_TIMEOUT_EN
                        r_idle <= '0;
`endif
                        if (w_hit) begin
                            r_match <= 1'b1;
                            r_cnt   <= w_cnt_inc;
                            r_fill  <= r_ovl ? w_fill_inc : '0;
                            if (r_thr != '0 && w_cnt_inc == r_thr) begin
                                r_irq   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_fill <= w_fill_inc;
                        end
                    end
`ifdef SEQDET_TIMEOUT_EN
                    // Long gap: forget any partial pattern.
                    else if (r_idle == TW'(TIMEOUT - 1)) begin
                        r_hist <= '0;
                        r_fill <= '0;
                        r_idle <= '0;
                    end else begin
                        r_idle <= r_idle + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    if (irq_clr) begin
                        r_irq   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign irq       = r_irq;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed scoreboard bench for seq_detect_ctrl.
// A second instance with CNT_W=2 covers counter saturation.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_thresh;
    logic       start;
    logic       stop;
    logic       in_bit;
    logic       in_valid;
    logic       match;
    logic [7:0] match_cnt;
    logic       irq;
    logic       irq_clr;
    logic       busy;

    logic       cfg_ready2;
    logic       match2;
    logic [1:0] match_cnt2;
    logic       irq2;
    logic       busy2;

    int checks = 0;
    int errors = 0;
    logic q[$];
    logic chk2 = 1'b0;

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .start(start), .stop(stop),
        .in(in_bit), .in_valid(in_valid),
        .match(match), .match_cnt(match_cnt),
        .irq(irq), .irq_clr(irq_clr), .busy(busy)
    );

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2), .TIMEOUT(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh[1:0]),
        .start(start), .stop(stop),
        .in(in_bit), .in_valid(in_valid),
        .match(match2), .match_cnt(match_cnt2),
        .irq(irq2), .irq_clr(irq_clr), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stream input; expected match is queued now and
    // popped once the DUT has had its edge.
    task automatic step(input logic b, input logic v, input logic s,
                        input logic e);
        logic exp_m;
        in_bit   = b;
        in_valid = v;
        stop     = s;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
        stop     = 1'b0;
        exp_m = q.pop_front();
        chk("match", {31'd0, match}, {31'd0, exp_m});
        if (chk2) chk("match2", {31'd0, match2}, {31'd0, exp_m});
    endtask

    // Feed n bits MSB first with the matching expected-pulse vector.
    task automatic feed(input logic [15:0] bits, input int n,
                        input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0, exp[i]);
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic [7:0] t);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_thresh  = t;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 0; cfg_pattern = 0; cfg_len = 0;
        cfg_overlap = 0; cfg_thresh = 0;
        start = 0; stop = 0; in_bit = 0; in_valid = 0; irq_clr = 0;
        tick();
        tick();
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1010 non-overlap, threshold 2
        load(8'b1010, 4'd4, 1'b0, 8'd2);
        arm();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        feed(16'b1010, 4, 16'b0001);
        chk("t1_cnt1", {24'd0, match_cnt}, 32'd1);
        chk("t1_irq1", {31'd0, irq}, 32'd0);
        feed(16'b1010, 4, 16'b0001);
        chk("t1_cnt2", {24'd0, match_cnt}, 32'd2);
        chk("t1_irq2", {31'd0, irq}, 32'd1);
        chk("t1_done_busy", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_done_cnt", {24'd0, match_cnt}, 32'd2);
        irq_clr = 1'b1;
        start   = 1'b1;
        tick();
        irq_clr = 1'b0;
        start   = 1'b0;
        chk("t1_clr_irq", {31'd0, irq}, 32'd0);
        chk("t1_clr_busy", {31'd0, busy}, 32'd0);
        chk("t1_keep_cnt", {24'd0, match_cnt}, 32'd2);
        tick();
        chk("t1_no_start", {31'd0, busy}, 32'd0);

        // overlap vs non-overlap on 1010101
        load(8'b1010, 4'd4, 1'b1, 8'd0);
        arm();
        feed(16'b1010101, 7, 16'b0001010);
        chk("t2_ovl_cnt", {24'd0, match_cnt}, 32'd2);
        chk("t2_ovl_irq", {31'd0, irq}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_stop_busy", {31'd0, busy}, 32'd0);
        load(8'b1010, 4'd4, 1'b0, 8'd0);
        arm();
        feed(16'b1010101, 7, 16'b0001000);
        chk("t2_novl_cnt", {24'd0, match_cnt}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // illegal length, then config offered during a run
        load(8'b1010, 4'd0, 1'b0, 8'd0);
        arm();
        chk("t3_len0_busy", {31'd0, busy}, 32'd0);
        load(8'b1010, 4'd9, 1'b0, 8'd0);
        arm();
        chk("t3_len9_busy", {31'd0, busy}, 32'd0);
        load(8'b1010, 4'd4, 1'b0, 8'd0);
        arm();
        chk("t3_busy", {31'd0, busy}, 32'd1);
        cfg_valid   = 1'b1;
        cfg_pattern = 8'b10;
        cfg_len     = 4'd2;
        #1;
        chk("t3_ready_run", {31'd0, cfg_ready}, 32'd0);
        feed(16'b1010, 4, 16'b0001);
        cfg_valid = 1'b0;
        chk("t3_cnt", {24'd0, match_cnt}, 32'd1);

        // stop together with the completing bit
        feed(16'b101, 3, 16'b000);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_cnt", {24'd0, match_cnt}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of a run
        load(8'b1010, 4'd4, 1'b0, 8'd0);
        arm();
        feed(16'b101, 3, 16'b000);
        rst_n = 1'b0;
        #2;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, cfg_ready}, 32'd1);
        chk("t5_cnt", {24'd0, match_cnt}, 32'd0);
        chk("t5_irq", {31'd0, irq}, 32'd0);
        chk("t5_match", {31'd0, match}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        arm();
        chk("t5_len_cleared", {31'd0, busy}, 32'd0);

        // CNT_W=2 saturation on the second instance
        load(8'b1, 4'd1, 1'b1, 8'd0);
        arm();
        chk2 = 1'b1;
        feed(16'b11111, 5, 16'b11111);
        chk2 = 1'b0;
        chk("t6_cnt2_sat", {30'd0, match_cnt2}, 32'd3);
        chk("t6_cnt", {24'd0, match_cnt}, 32'd5);
        chk("t6_irq2", {31'd0, irq2}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // 101, four idle cycles, then 0
        load(8'b1010, 4'd4, 1'b0, 8'd0);
        arm();
        feed(16'b101, 3, 16'b000);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEQDET_TIMEOUT_EN
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t7_cnt", {24'd0, match_cnt}, 32'd0);
`else
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t7_cnt", {24'd0, match_cnt}, 32'd1);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t7_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
